dff_pipeline: RTL and testbench

- Parametrised elastic register pipeline. Successor to the fixed 4-bit DFF stage: generalised in data width and stage count.
- Adds a valid/ready handshake on both sides, bubble collapsing, synchronous flush and an occupancy count.
- Sits between datapath blocks (ALU, parallel-to-serial converter) to retime data and absorb back-pressure.

---
 rtl/dff_pipeline.sv | 133 +++++++++++++
 tb/tb_dff_pipeline.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipeline.sv
// Elastic valid/ready register pipeline with bubble collapsing, flush and occupancy count.
// Optional per-stage parity tracking is enabled with `define DFF_PIPELINE_PARITY_EN.
module dff_pipeline #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
`ifdef DFF_PIPELINE_PARITY_EN
    input  logic                         err_inject,
    output logic                         out_par_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] ready;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_xfer, out_xfer;

    // A stage can load when it or any stage downstream of it is empty, or the sink drains.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            acc = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                acc = acc | !v_q[j];
            end
            ready[k] = acc;
        end
    end

    assign in_ready  = ready[0] & !flush;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = v_q[DEPTH-1] & out_ready;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            d_d[k] = d_q[k];
        end
        if (ready[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = in_data;
            end
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (ready[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    d_d[k] = d_q[k-1];
                end
            end
        end
        // Flush drops every valid bit but leaves the data registers untouched.
        if (flush) begin
            v_d = '0;
        end
    end

    always_comb begin
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

`ifdef DFF_PIPELINE_PARITY_EN
    logic [DEPTH-1:0] p_q, p_d;

    // Parity travels with the data; err_inject corrupts it at capture time.
    always_comb begin
        p_d = p_q;
        if (ready[0] && in_valid) begin
            p_d[0] = (^in_data) ^ err_inject;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (ready[k] && v_q[k-1]) begin
                p_d[k] = p_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign out_par_err = v_q[DEPTH-1] & (p_q[DEPTH-1] != (^d_q[DEPTH-1]));
`endif

    occupancy_matches_valids: assert property (
        @(posedge clk) disable iff (rst) occ_q == OCC_W'($countones(v_q))
    );

endmodule

// File: tb/tb_dff_pipeline.sv
// Directed, table-driven bench for dff_pipeline (WIDTH=4, DEPTH=3).
module tb_dff_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] occupancy;
`ifdef DFF_PIPELINE_PARITY_EN
    logic       err_inject;
    logic       out_par_err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dff_pipeline #(.WIDTH(4), .DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef DFF_PIPELINE_PARITY_EN
        .err_inject (err_inject),
        .out_par_err(out_par_err),
`endif
        .occupancy  (occupancy)
    );

    typedef struct {
        logic       iv;
        logic [3:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_od;
        logic [1:0] e_occ;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic iv, input logic [3:0] id, input logic ordy,
                                input logic fl, input logic e_ir, input logic e_ov,
                                input logic [3:0] e_od, input logic [1:0] e_occ);
        vec_t r;
        r.iv = iv; r.id = id; r.ordy = ordy; r.fl = fl;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.e_occ = e_occ;
        vq.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
`ifdef DFF_PIPELINE_PARITY_EN
        err_inject = 1'b0;
`endif

        // Each row: inputs for one cycle, then the outputs expected before that cycle's edge.
        // Streaming
        add(1, 4'hC, 1, 0,  1, 0, 4'h0, 0);
        add(1, 4'h3, 1, 0,  1, 0, 4'h0, 1);
        add(1, 4'hA, 1, 0,  1, 0, 4'h0, 2);
        add(0, 4'h0, 1, 0,  1, 1, 4'hC, 3);
        add(0, 4'h0, 1, 0,  1, 1, 4'h3, 2);
        add(0, 4'h0, 1, 0,  1, 1, 4'hA, 1);
        add(0, 4'h0, 1, 0,  1, 0, 4'h0, 0);
        // Back-pressure
        add(1, 4'hC, 0, 0,  1, 0, 4'h0, 0);
        add(1, 4'h3, 0, 0,  1, 0, 4'h0, 1);
        add(1, 4'hA, 0, 0,  1, 0, 4'h0, 2);
        add(1, 4'h5, 0, 0,  0, 1, 4'hC, 3);
        add(1, 4'h5, 0, 0,  0, 1, 4'hC, 3);
        add(1, 4'h5, 1, 0,  1, 1, 4'hC, 3);
        add(0, 4'h0, 0, 0,  0, 1, 4'h3, 3);
        add(0, 4'h0, 1, 0,  1, 1, 4'h3, 3);
        add(0, 4'h0, 1, 0,  1, 1, 4'hA, 2);
        add(0, 4'h0, 1, 0,  1, 1, 4'h5, 1);
        add(0, 4'h0, 1, 0,  1, 0, 4'h0, 0);
        // Bubble collapse
        add(1, 4'hC, 0, 0,  1, 0, 4'h0, 0);
        add(0, 4'h0, 0, 0,  1, 0, 4'h0, 1);
        add(0, 4'h0, 0, 0,  1, 0, 4'h0, 1);
        add(1, 4'h3, 0, 0,  1, 1, 4'hC, 1);
        add(0, 4'h0, 0, 0,  1, 1, 4'hC, 2);
        add(0, 4'h0, 1, 0,  1, 1, 4'hC, 2);
        add(0, 4'h0, 1, 0,  1, 1, 4'h3, 1);
        add(0, 4'h0, 1, 0,  1, 0, 4'h0, 0);
        // Flush
        add(1, 4'hC, 0, 0,  1, 0, 4'h0, 0);
        add(1, 4'h3, 0, 0,  1, 0, 4'h0, 1);
        add(1, 4'hF, 0, 1,  0, 0, 4'h0, 2);
        add(0, 4'h0, 1, 0,  1, 0, 4'h0, 0);
        add(0, 4'h0, 1, 0,  1, 0, 4'h0, 0);
        add(0, 4'h0, 1, 0,  1, 0, 4'h0, 0);

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef DFF_PIPELINE_PARITY_EN
        check("rst_par_err",   32'(out_par_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            in_valid  = vq[i].iv;
            in_data   = vq[i].id;
            out_ready = vq[i].ordy;
            flush     = vq[i].fl;
            #1;
            check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vq[i].e_ir));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
            check($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vq[i].e_occ));
            if (vq[i].e_ov) begin
                check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vq[i].e_od));
            end
        end

        // Asynchronous reset with a full pipeline
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'h1; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        in_data = 4'h2;
        @(negedge clk);
        in_data = 4'h3;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_occupancy", 32'(occupancy), 32'd3);
        check("full_out_data",  32'(out_data),  32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data",  32'(out_data),  32'd0);
        check("arst_occupancy", 32'(occupancy), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'h6; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("post_rst_out_valid_1", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_out_valid_2", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_out_valid_3", 32'(out_valid), 32'd1);
        check("post_rst_out_data",    32'(out_data),  32'h6);
        @(negedge clk);
        #1;
        check("post_rst_drained", 32'(occupancy), 32'd0);

`ifdef DFF_PIPELINE_PARITY_EN
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'hC; err_inject = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_data = 4'h3; err_inject = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("par_c_data",    32'(out_data),    32'hC);
        check("par_c_err",     32'(out_par_err), 32'd1);
        @(negedge clk);
        #1;
        check("par_3_data",    32'(out_data),    32'h3);
        check("par_3_err",     32'(out_par_err), 32'd0);
        @(negedge clk);
        #1;
        check("par_empty_err", 32'(out_par_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
